// File: rtl/synth_pkg.sv
// Types and constants shared by the CPU-side synth control blocks.
// Holds the carrier FCW type, the allocator state enum and an index-width helper.
package synth_pkg;
    localparam int FCW_W = 24;

    typedef logic [FCW_W-1:0] fcw_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } alloc_state_t;

    // Keeps voice indices at least one bit wide even for a single voice.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// Note-event input and CDC-facing voice register bundle of voice_allocator.
// master = event source / CDC side, slave = allocator.
interface voice_allocator_if #(
    parameter int N_VOICES = 4
);
    import synth_pkg::*;

    localparam int CNT_W = $clog2(N_VOICES + 1);

    logic                    ev_valid;
    logic                    ev_ready;
    logic                    ev_on;
    fcw_t                    ev_fcw;
    fcw_t [N_VOICES-1:0]     car_fcw;
    logic [N_VOICES-1:0]     note_en;
    logic                    tx_en;
    logic                    tx_ack;
    logic [CNT_W-1:0]        active_cnt;
    logic                    drop;

    modport master (
        output ev_valid, ev_on, ev_fcw, tx_ack,
        input  ev_ready, car_fcw, note_en, tx_en, active_cnt, drop
    );

    modport slave (
        input  ev_valid, ev_on, ev_fcw, tx_ack,
        output ev_ready, car_fcw, note_en, tx_en, active_cnt, drop
    );
endinterface

// File: rtl/voice_pick.sv
// Combinational priority finder: lowest free voice, lowest enabled voice matching fcw,
// and (VOICE_STEAL_EN only) the oldest enabled voice, ties to the lowest index.
module voice_pick
    import synth_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int IDX_W    = 2
`ifdef VOICE_STEAL_EN
    ,
    parameter int AGE_W    = 8
`endif
) (
    input  logic [N_VOICES-1:0]            note_en,
    input  fcw_t [N_VOICES-1:0]            car_fcw,
    input  fcw_t                           fcw,
    output logic [IDX_W-1:0]               free_idx,
    output logic                           free_vld,
    output logic [IDX_W-1:0]               match_idx,
    output logic                           match_vld
`ifdef VOICE_STEAL_EN
    ,
    input  logic [N_VOICES-1:0][AGE_W-1:0] age,
    output logic [IDX_W-1:0]               old_idx,
    output logic                           old_vld
`endif
);
    always_comb begin
        free_idx  = '0;
        free_vld  = 1'b0;
        match_idx = '0;
        match_vld = 1'b0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (!free_vld && !note_en[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (!match_vld && note_en[i] && (car_fcw[i] == fcw)) begin
                match_vld = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Strict greater-than keeps the lowest index on equal ages.
    always_comb begin
        old_idx = '0;
        old_vld = 1'b0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (note_en[i] && (!old_vld || (age[i] > age[old_idx]))) begin
                old_vld = 1'b1;
                old_idx = IDX_W'(i);
            end
        end
    end
`endif
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler publishing car_fcw/note_en through a 4-phase req/ack; VOICE_STEAL_EN enables oldest-voice stealing.
// Register updates at the accept edge, tx_en from that edge; ev_ready low from REQ until ack returns low.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int AGE_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = idx_w(N_VOICES);
    localparam int CNT_W = $clog2(N_VOICES + 1);

    if ((N_VOICES < 1) || (AGE_W < 1)) begin : g_bad_cfg
        $error("voice_allocator: N_VOICES and AGE_W must both be at least 1");
    end

    alloc_state_t        state_q, state_d;
    fcw_t [N_VOICES-1:0] car_q, car_d;
    logic [N_VOICES-1:0] en_q, en_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_en_q, drop_q, drop_d;
    logic                accept, changed;
    logic [IDX_W-1:0]    free_idx, match_idx;
    logic                free_vld, match_vld;
`ifdef VOICE_STEAL_EN
    logic [N_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    logic [IDX_W-1:0]               old_idx, alloc_idx;
    logic                           old_vld;
`endif

    voice_pick #(
        .N_VOICES (N_VOICES),
        .IDX_W    (IDX_W)
`ifdef VOICE_STEAL_EN
        ,
        .AGE_W    (AGE_W)
`endif
    ) u_pick (
        .note_en   (en_q),
        .car_fcw   (car_q),
        .fcw       (bus.ev_fcw),
        .free_idx  (free_idx),
        .free_vld  (free_vld),
        .match_idx (match_idx),
        .match_vld (match_vld)
`ifdef VOICE_STEAL_EN
        ,
        .age       (age_q),
        .old_idx   (old_idx),
        .old_vld   (old_vld)
`endif
    );

    assign accept = bus.ev_valid && (state_q == IDLE);

    // Voice register updates only happen on acceptance, i.e. in IDLE, which freezes them during the handshake.
    always_comb begin
        car_d   = car_q;
        en_d    = en_q;
        drop_d  = 1'b0;
        changed = 1'b0;
        if (accept) begin
            if (bus.ev_on) begin
                if ((bus.ev_fcw != '0) && !match_vld) begin
                    if (free_vld) begin
                        car_d[free_idx] = bus.ev_fcw;
                        en_d[free_idx]  = 1'b1;
                        changed         = 1'b1;
`ifdef VOICE_STEAL_EN
                    end else if (old_vld) begin
                        car_d[old_idx] = bus.ev_fcw;
                        changed        = 1'b1;
                    end
`else
                    end else begin
                        drop_d = 1'b1;
                    end
`endif
                end
            end else if (match_vld) begin
                en_d[match_idx] = 1'b0;
                changed         = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            cnt_d = cnt_d + CNT_W'(en_d[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (changed)     state_d = REQ;
            REQ:     if (bus.tx_ack)  state_d = RELEASE;
            RELEASE: if (!bus.tx_ack) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            car_q   <= '0;
            en_q    <= '0;
            cnt_q   <= '0;
            tx_en_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            car_q   <= car_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            tx_en_q <= (state_d == REQ);
            drop_q  <= drop_d;
        end
    end

`ifdef VOICE_STEAL_EN
    // Any note-on that changed registers is an allocation, either into a free voice or a stolen one.
    assign alloc_idx = free_vld ? free_idx : old_idx;

    always_comb begin
        age_d = age_q;
        if (changed && bus.ev_on) begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (IDX_W'(i) == alloc_idx) begin
                    age_d[i] = '0;
                end else if (en_q[i] && (age_q[i] != '1)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    assign bus.ev_ready   = (state_q == IDLE);
    assign bus.car_fcw    = car_q;
    assign bus.note_en    = en_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.active_cnt = cnt_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a reference voice model pushes expected snapshots, popped after each accept edge.
// Build with or without VOICE_STEAL_EN; the model follows the same macro.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    voice_allocator_if #(.N_VOICES(NV)) bus ();

    voice_allocator #(.N_VOICES(NV), .AGE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NV-1:0][23:0] car;
        logic [NV-1:0]       en;
        logic [2:0]          cnt;
        logic                tx;
        logic                drp;
        logic                rdy;
    } snap_t;

    snap_t         sb[$];
    fcw_t          m_car [NV];
    logic [NV-1:0] m_en;
    logic [7:0]    m_age [NV];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic snap_t observe();
        snap_t s;
        s.car = bus.car_fcw;
        s.en  = bus.note_en;
        s.cnt = bus.active_cnt;
        s.tx  = bus.tx_en;
        s.drp = bus.drop;
        s.rdy = bus.ev_ready;
        return s;
    endfunction

    function automatic snap_t model_snap(input bit chg, input bit drp);
        snap_t s;
        for (int i = 0; i < NV; i++) s.car[i] = m_car[i];
        s.en  = m_en;
        s.cnt = 3'($countones(m_en));
        s.tx  = chg;
        s.drp = drp;
        s.rdy = !chg;
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_car[i] = '0;
            m_age[i] = '0;
        end
        m_en = '0;
    endtask

    task automatic model_alloc(input int v, input fcw_t fcw);
        for (int i = 0; i < NV; i++)
            if (i != v && m_en[i] && m_age[i] != 8'hFF) m_age[i] = m_age[i] + 8'd1;
        m_age[v] = '0;
        m_car[v] = fcw;
        m_en[v]  = 1'b1;
    endtask

    task automatic model_ev(input bit on, input fcw_t fcw, output bit chg, output bit drp);
        int m = -1;
        int f = -1;
        chg = 1'b0;
        drp = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m < 0 && m_en[i] && m_car[i] == fcw) m = i;
            if (f < 0 && !m_en[i]) f = i;
        end
        if (on) begin
            if (fcw != '0 && m < 0) begin
                if (f >= 0) begin
                    model_alloc(f, fcw);
                    chg = 1'b1;
                end else begin
`ifdef VOICE_STEAL_EN
                    int o = 0;
                    for (int i = 1; i < NV; i++) if (m_age[i] > m_age[o]) o = i;
                    model_alloc(o, fcw);
                    chg = 1'b1;
`else
                    drp = 1'b1;
`endif
                end
            end
        end else if (m >= 0) begin
            m_en[m] = 1'b0;
            chg     = 1'b1;
        end
    endtask

    // Called and returns at a negedge; drives one event and scores the cycle after acceptance.
    task automatic send_ev(input bit on, input fcw_t fcw, input string name, output bit chg);
        bit    drp;
        snap_t e;
        snap_t o;
        int    w = 0;
        chg = 1'b0;
        while (bus.ev_ready !== 1'b1 && w < 50) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        n_vec++;
        if (bus.ev_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_timeout: ev_ready=%b required 1", name, bus.ev_ready);
            return;
        end
        bus.ev_valid = 1'b1;
        bus.ev_on    = on;
        bus.ev_fcw   = fcw;
        model_ev(on, fcw, chg, drp);
        sb.push_back(model_snap(chg, drp));
        @(posedge clk); @(negedge clk);
        bus.ev_valid = 1'b0;
        e = sb.pop_front();
        o = observe();
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: car=%h en=%b cnt=%0d tx=%b drop=%b rdy=%b required car=%h en=%b cnt=%0d tx=%b drop=%b rdy=%b",
                     name, o.car, o.en, o.cnt, o.tx, o.drp, o.rdy, e.car, e.en, e.cnt, e.tx, e.drp, e.rdy);
        end
    endtask

    task automatic do_ack(input string name);
        bus.tx_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus.tx_en !== 1'b0 || bus.ev_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack_high: tx_en=%b ev_ready=%b required 0 0", name, bus.tx_en, bus.ev_ready);
        end
        bus.tx_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus.ev_ready !== 1'b1 || bus.tx_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack_low: ev_ready=%b tx_en=%b required 1 0", name, bus.ev_ready, bus.tx_en);
        end
    endtask

    task automatic reset_dut();
        bus.ev_valid = 1'b0;
        bus.ev_on    = 1'b0;
        bus.ev_fcw   = '0;
        bus.tx_ack   = 1'b0;
        rst_n        = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        snap_t o;
        reset_dut();
        sb.push_back(model_snap(1'b0, 1'b0));
        o = observe();
        n_vec++;
        if (o !== sb[0]) begin
            n_err++;
            $display("FAIL reset_state: car=%h en=%b cnt=%0d tx=%b drop=%b rdy=%b required all zero, rdy=1",
                     o.car, o.en, o.cnt, o.tx, o.drp, o.rdy);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_first_note();
        bit chg;
        reset_dut();
        send_ev(1'b1, 24'h001000, "first_on", chg);
        n_vec++;
        if (bus.note_en !== 4'b0001 || bus.car_fcw[0] !== 24'h001000 || bus.tx_en !== 1'b1 || bus.ev_ready !== 1'b0) begin
            n_err++;
            $display("FAIL first_on_regs: en=%b car0=%h tx=%b rdy=%b required 0001 001000 1 0",
                     bus.note_en, bus.car_fcw[0], bus.tx_en, bus.ev_ready);
        end
        do_ack("first_on");
        n_vec++;
        if (bus.active_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL first_on_cnt: active_cnt=%0d required 1", bus.active_cnt);
        end
    endtask

    task automatic test_fifth_note();
        bit chg;
        reset_dut();
        for (int i = 1; i <= 4; i++) begin
            send_ev(1'b1, fcw_t'(i * 16), "fill", chg);
            if (chg) do_ack("fill");
        end
        send_ev(1'b1, 24'h50, "fifth_on", chg);
`ifdef VOICE_STEAL_EN
        n_vec++;
        if (bus.car_fcw[0] !== 24'h50 || bus.note_en !== 4'hF || bus.tx_en !== 1'b1) begin
            n_err++;
            $display("FAIL steal: car0=%h en=%b tx=%b required 000050 1111 1", bus.car_fcw[0], bus.note_en, bus.tx_en);
        end
        if (chg) do_ack("steal");
`else
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus.drop !== 1'b0 || bus.tx_en !== 1'b0 || bus.note_en !== 4'hF || bus.car_fcw[0] !== 24'h10) begin
            n_err++;
            $display("FAIL drop_pulse_end: drop=%b tx=%b en=%b car0=%h required 0 0 1111 000010",
                     bus.drop, bus.tx_en, bus.note_en, bus.car_fcw[0]);
        end
`endif
    endtask

    task automatic test_note_off();
        bit chg;
        reset_dut();
        send_ev(1'b1, 24'h10, "off_setup_a", chg);
        if (chg) do_ack("off_setup_a");
        send_ev(1'b1, 24'h20, "off_setup_b", chg);
        if (chg) do_ack("off_setup_b");
        send_ev(1'b0, 24'h20, "off_match", chg);
        n_vec++;
        if (bus.note_en !== 4'b0001 || bus.car_fcw[1] !== 24'h20) begin
            n_err++;
            $display("FAIL off_match_regs: en=%b car1=%h required 0001 000020", bus.note_en, bus.car_fcw[1]);
        end
        if (chg) do_ack("off_match");
        send_ev(1'b0, 24'h99, "off_nomatch", chg);
    endtask

    task automatic test_noop();
        bit chg;
        reset_dut();
        send_ev(1'b1, 24'h10, "noop_setup", chg);
        if (chg) do_ack("noop_setup");
        send_ev(1'b1, 24'h10, "noop_retrig", chg);
        send_ev(1'b1, 24'h0, "noop_zero", chg);
        send_ev(1'b1, 24'h10, "noop_retrig2", chg);
    endtask

    task automatic test_backpressure();
        bit chg;
        reset_dut();
        send_ev(1'b1, 24'h10, "bp_first", chg);
        bus.ev_valid = 1'b1;
        bus.ev_on    = 1'b1;
        bus.ev_fcw   = 24'h20;
        bus.tx_ack   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (bus.ev_ready !== 1'b0 || bus.note_en !== 4'b0001 || bus.tx_en !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: ev_ready=%b en=%b tx=%b required 0 0001 0",
                         c, bus.ev_ready, bus.note_en, bus.tx_en);
            end
        end
        bus.tx_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus.ev_ready !== 1'b1 || bus.note_en !== 4'b0001 || bus.tx_en !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: ev_ready=%b en=%b tx=%b required 1 0001 0", bus.ev_ready, bus.note_en, bus.tx_en);
        end
        send_ev(1'b1, 24'h20, "bp_second", chg);
        if (chg) do_ack("bp_second");
    endtask

    task automatic test_reset_mid();
        bit    chg;
        snap_t o;
        reset_dut();
        send_ev(1'b1, 24'h30, "mid_on", chg);
        rst_n = 1'b0;
        model_clear();
        sb.push_back(model_snap(1'b0, 1'b0));
        @(posedge clk); @(negedge clk);
        o = observe();
        n_vec++;
        if (o !== sb[0]) begin
            n_err++;
            $display("FAIL reset_mid: car=%h en=%b cnt=%0d tx=%b drop=%b rdy=%b required all zero, rdy=1",
                     o.car, o.en, o.cnt, o.tx, o.drp, o.rdy);
        end
        void'(sb.pop_front());
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus.ev_ready !== 1'b1 || bus.tx_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release: ev_ready=%b tx=%b required 1 0", bus.ev_ready, bus.tx_en);
        end
    endtask

    task automatic test_random();
        bit   chg;
        bit   on;
        fcw_t fcw;
        reset_dut();
        for (int k = 0; k < 60; k++) begin
            on  = ($urandom_range(0, 99) < 65);
            fcw = fcw_t'($urandom_range(0, 6) * 16);
            send_ev(on, fcw, "random", chg);
            if (chg) do_ack("random");
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_on    = 1'b0;
        bus.ev_fcw   = '0;
        bus.tx_ack   = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_first_note();
        test_fifth_note();
        test_note_off();
        test_noop();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
